sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Parametrised single-clock FIFO. It is the buffered successor to the library's Register, Counter and Memory blocks.
- Decouples a producer (e.g. input/event capture) from a consumer (e.g. game-logic FSM) across multiple cycles.
- Read port is first-word-fall-through: the head word is always visible, with occupancy and threshold flags.
- Adds flush, almost-full/almost-empty and error reporting, none of which the plain Memory block has.

Parameters:
- WIDTH, 8: data word width in bits (>=1).
- DEPTH, 16: number of storage entries; power of two, >=2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clock  input  1  system clock, all state on posedge.
- reset_L  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush; empties FIFO.
- we  input  1  write request.
- wdata  input  WIDTH  write data.
- re  input  1  read (pop) request.
- rdata  output  WIDTH  head-of-queue word (FWFT).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write rejected last cycle.
- underflow  output  1  one-cycle pulse: read rejected last cycle.

Behaviour:
- Reset (reset_L low, async): wr_ptr=rd_ptr=0, count=0, overflow=underflow=0. Therefore empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), which is 0 for legal values. Storage array is not reset.
- Reset asserted mid-operation discards all contents immediately. The first accepted write after reset release lands in entry 0.
- Pointers are $clog2(DEPTH)+1 bits. The low bits index storage and the MSB distinguishes full from empty. Pointers wrap naturally modulo 2*DEPTH.
- wr_acc = we & ~full; rd_acc = re & ~empty. Acceptance is evaluated on flags from the current cycle.
- On wr_acc: mem[wr_ptr] <= wdata; wr_ptr+1.
- On rd_acc: rd_ptr+1.
- count next = count + wr_acc - rd_acc.
- Simultaneous we & re when 0<count<DEPTH: both are accepted and count is unchanged.
- When empty with we & re: the write is accepted, the read is rejected, count goes to 1, and underflow pulses.
- When full with we & re: the read is accepted, the write is rejected, count goes to DEPTH-1, and overflow pulses. There is no same-cycle write-through.
- overflow <= we & full; underflow <= re & empty. Both are registered, high for exactly one cycle per rejected request, and not sticky.
- clear: highest priority after reset. Pointers and count go to 0 on the next edge, and any we/re in that cycle is ignored. overflow/underflow are 0 the cycle after clear.
- rdata = mem[rd_ptr[low bits]] combinationally when ~empty, and '0 when empty.
- A word written at edge N is visible on rdata after edge N when the FIFO was empty, giving 1-cycle write-to-read latency.
- full, empty, almost_full and almost_empty are derived combinationally from registered count/pointers; there are no glitch paths from we/re.
- Illegal parameters (DEPTH not a power of two, AF/AE out of range) are caught by elaboration-time assertions.

Decomposition:
- No shared package is needed; all types derive from parameters.
- localparam AW=$clog2(DEPTH) is local to the module.
- One natural sub-module, fifo_ram: dual-port storage with a synchronous write port (clock, we, waddr, wdata) and an asynchronous read port (raddr, rdata), parametrised DW/W.
- The pointer, count and flag logic stays in sync_fifo.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, full=0, count=0, rdata=0, no error pulses.
- Write 0x11,0x22,0x33 on consecutive cycles, then pop 3 -> rdata shows 0x11 the cycle after the first write; rdata sequence 0x11,0x22,0x33; count goes 1,2,3,2,1,0; empty re-asserts.
- Write 16 words 0x00..0x0F -> almost_full rises at count=14, full at 16. A 17th write of 0xAA -> overflow pulses 1 cycle, count stays 16, and the later drain returns 0x00..0x0F with no 0xAA.
- Full FIFO, we=1 re=1 with wdata=0x55 -> read accepted, write rejected, overflow=1, count=15.
- Empty FIFO, we=1 re=1 with wdata=0x77 -> underflow=1, count=1, rdata=0x77.
- Run 40 write/read pairs to wrap pointers, then assert clear with we=1 (count=5) -> next cycle count=0, empty=1. Then assert reset_L low mid-burst -> flags return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the sync_fifo block: parameter legality checks used
// at elaboration time by the FIFO top.
package sync_fifo_pkg;

  // True when v is a power of two and at least 2 (legal FIFO depth).
  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // True when lo <= v <= hi.
  function automatic bit in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Dual-port storage for sync_fifo: synchronous write port, asynchronous
// read port. Contents are intentionally not reset.
module sync_fifo_ram #(
  parameter int DW = 8,
  parameter int W  = 4
) (
  input  logic          clock,
  input  logic          we,
  input  logic [W-1:0]  waddr,
  input  logic [DW-1:0] wdata,
  input  logic [W-1:0]  raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**W];

  // Store the incoming word on an accepted write.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Combinational read so the head word falls through without latency.
  always_comb begin
    rdata = mem_r[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy, threshold
// flags, synchronous flush and one-cycle overflow/underflow pulses.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clock,
  input  logic                     reset_L,
  input  logic                     clear,
  input  logic                     we,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_C  = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_C  = AE_LEVEL[AW:0];
  localparam logic [AW:0] ONE_C = {{AW{1'b0}}, 1'b1};

  // Reject illegal parameterisations while elaborating.
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end
  if (!in_range(AF_LEVEL, 1, DEPTH)) begin : g_bad_af
    $error("sync_fifo: AF_LEVEL must be within 1..DEPTH");
  end
  if (!in_range(AE_LEVEL, 0, DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo: AE_LEVEL must be within 0..DEPTH-1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo: WIDTH must be >= 1");
  end

  // Pointers carry one extra MSB so equal low bits can mean full or empty.
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      count_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             full_s;
  logic             empty_s;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             ram_we_s;
  logic [AW:0]      count_nxt_s;
  logic [WIDTH-1:0] ram_rdata_s;

  // Status flags come only from registered state, never from we/re.
  always_comb begin
    empty_s  = (wr_ptr_r == rd_ptr_r);
    full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
               (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    wr_acc_s = we & ~full_s;
    rd_acc_s = re & ~empty_s;
    ram_we_s = wr_acc_s & ~clear;
  end

  // Occupancy update: +1 on accepted write, -1 on accepted read.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + ONE_C;
      2'b01:   count_nxt_s = count_r - ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, count and error-pulse registers; flush wins over traffic.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (clear) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_C;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_C;
      end
      count_r     <= count_nxt_s;
      overflow_r  <= we & full_s;
      underflow_r <= re & empty_s;
    end
  end

  sync_fifo_ram #(
    .DW (WIDTH),
    .W  (AW)
  ) u_ram (
    .clock (clock),
    .we    (ram_we_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (ram_rdata_s)
  );

  // Drive outputs; the head word reads as zero while the FIFO is empty.
  always_comb begin
    if (empty_s) begin
      rdata = {WIDTH{1'b0}};
    end else begin
      rdata = ram_rdata_s;
    end
    full         = full_s;
    empty        = empty_s;
    almost_full  = (count_r >= AF_C);
    almost_empty = (count_r <= AE_C);
    count        = count_r;
    overflow     = overflow_r;
    underflow    = underflow_r;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (WIDTH=8, DEPTH=16).
module tb_sync_fifo;

  logic       clock;
  logic       reset_L;
  logic       clear;
  logic       we;
  logic [7:0] wdata;
  logic       re;
  logic [7:0] rdata;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int n_pass;
  int n_total;

  sync_fifo #(
    .WIDTH    (8),
    .DEPTH    (16),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clock        (clock),
    .reset_L      (reset_L),
    .clear        (clear),
    .we           (we),
    .wdata        (wdata),
    .re           (re),
    .rdata        (rdata),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle_flags(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"},  32'(full),  32'd0);
    chk({tag, "_ae"},    32'(almost_empty), 32'd1);
    chk({tag, "_af"},    32'(almost_full),  32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset_L = 1'b0;
    clear   = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    wdata   = 8'h00;

    // Reset state
    #2;
    chk_idle_flags("reset");
    chk("reset_ovf", 32'(overflow),  32'd0);
    chk("reset_unf", 32'(underflow), 32'd0);
    @(negedge clock);
    reset_L = 1'b1;
    tick();
    chk_idle_flags("idle");
    chk("idle_unf", 32'(underflow), 32'd0);

    // Three writes then three pops
    we = 1'b1; wdata = 8'h11;
    tick();
    chk("w1_count", 32'(count), 32'd1);
    chk("w1_rdata", 32'(rdata), 32'h11);
    chk("w1_empty", 32'(empty), 32'd0);
    wdata = 8'h22;
    tick();
    chk("w2_count", 32'(count), 32'd2);
    chk("w2_rdata", 32'(rdata), 32'h11);
    wdata = 8'h33;
    tick();
    chk("w3_count", 32'(count), 32'd3);
    chk("w3_ae",    32'(almost_empty), 32'd0);
    we = 1'b0; re = 1'b1;
    tick();
    chk("r1_count", 32'(count), 32'd2);
    chk("r1_rdata", 32'(rdata), 32'h22);
    tick();
    chk("r2_count", 32'(count), 32'd1);
    chk("r2_rdata", 32'(rdata), 32'h33);
    tick();
    chk("r3_count", 32'(count), 32'd0);
    chk("r3_empty", 32'(empty), 32'd1);
    chk("r3_rdata", 32'(rdata), 32'd0);
    chk("r3_unf",   32'(underflow), 32'd0);
    re = 1'b0;

    // Fill to 16, checking thresholds on the way
    we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata = 8'(i);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af",    32'(almost_full),  32'((i + 1) >= 14));
      chk("fill_ae",    32'(almost_empty), 32'((i + 1) <= 2));
      chk("fill_full",  32'(full),         32'((i + 1) == 16));
    end
    chk("full_head", 32'(rdata), 32'h00);

    // Write while full is rejected
    wdata = 8'hAA;
    tick();
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_head",  32'(rdata), 32'h00);
    we = 1'b0;
    tick();
    chk("ovf_clear", 32'(overflow), 32'd0);
    chk("ovf_count2", 32'(count), 32'd16);

    // Full with simultaneous read and write: read only
    we = 1'b1; re = 1'b1; wdata = 8'h55;
    tick();
    chk("fwr_ovf",   32'(overflow), 32'd1);
    chk("fwr_count", 32'(count), 32'd15);
    chk("fwr_rdata", 32'(rdata), 32'h01);
    chk("fwr_full",  32'(full), 32'd0);

    // Drain remaining 0x01..0x0F, no 0xAA or 0x55 present
    we = 1'b0;
    for (int i = 1; i < 16; i++) begin
      chk("drain_rdata", 32'(rdata), 32'(i));
      tick();
      chk("drain_count", 32'(count), 32'(15 - i));
      chk("drain_ovf",   32'(overflow), 32'd0);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_rdata0", 32'(rdata), 32'd0);

    // Empty with simultaneous read and write: write only
    we = 1'b1; re = 1'b1; wdata = 8'h77;
    tick();
    chk("ewr_unf",   32'(underflow), 32'd1);
    chk("ewr_count", 32'(count), 32'd1);
    chk("ewr_rdata", 32'(rdata), 32'h77);
    we = 1'b0; re = 1'b0;
    tick();
    chk("ewr_unf_clr", 32'(underflow), 32'd0);
    re = 1'b1;
    tick();
    chk("ewr_pop", 32'(count), 32'd0);
    re = 1'b0;

    // 40 write/read pairs to wrap the pointers
    we = 1'b1; wdata = 8'h00;
    tick();
    re = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wdata = 8'(i + 1);
      tick();
      chk("wrap_count", 32'(count), 32'd1);
      chk("wrap_rdata", 32'(rdata), 32'(i + 1));
    end
    re = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wdata = 8'(8'hE0 + i);
      tick();
    end
    chk("pre_clr_count", 32'(count), 32'd5);
    chk("pre_clr_head",  32'(rdata), 32'd40);

    // Flush with traffic present
    clear = 1'b1; we = 1'b1; re = 1'b1; wdata = 8'h99;
    tick();
    chk_idle_flags("clr");
    chk("clr_ovf", 32'(overflow),  32'd0);
    chk("clr_unf", 32'(underflow), 32'd0);
    clear = 1'b0; re = 1'b0; wdata = 8'hC3;
    tick();
    chk("post_clr_count", 32'(count), 32'd1);
    chk("post_clr_rdata", 32'(rdata), 32'hC3);

    // Asynchronous reset mid-burst
    wdata = 8'hC4;
    tick();
    wdata = 8'hC5;
    tick();
    chk("burst_count", 32'(count), 32'd3);
    #3;
    reset_L = 1'b0;
    #1;
    chk_idle_flags("areset");
    we = 1'b0;
    @(negedge clock);
    reset_L = 1'b1;
    we = 1'b1; wdata = 8'h5A;
    tick();
    chk("rst_wr_count", 32'(count), 32'd1);
    chk("rst_wr_rdata", 32'(rdata), 32'h5A);
    we = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
